store_buffer: RTL and testbench

Posted-write store buffer between the ARM core's data port and data memory. Core stores (MemWrite, DataAdr, WriteData) are captured into a FIFO in one cycle and drained to memory over a valid/ready handshake, so a slow or busy memory does not cost store latency. Loads are checked against pending stores so the core never reads stale data.

---
 rtl/store_buffer.sv | 145 ++++++++++++++
 tb/tb_store_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer: core stores are queued in a FIFO and drained to memory in order.
// Optional STORE_BUFFER_FWD_EN forwards matching pending stores to loads instead of stalling them.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_fwd,
    output logic [DW-1:0]              ld_data,
    output logic                       ld_stall,
    output logic                       mem_valid,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_data,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] addr_mem_r [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_r;
    logic          empty_r;

    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] count_nxt_s;
    logic          hit_s;
    logic [PW-1:0] idx_s;
    logic [CW-1:0] off_s;
`ifdef STORE_BUFFER_FWD_EN
    logic [DW-1:0] hit_data_s;
`endif
    logic [1:0]    ld_addr_unused_s;

    // Byte-offset bits do not take part in the word-granular load check.
    assign ld_addr_unused_s = ld_addr[1:0];

    assign push_s    = st_valid & ~full_r;
    assign pop_s     = ~empty_r & mem_ready;
    assign st_ready  = ~full_r;
    assign mem_valid = ~empty_r;
    assign mem_addr  = addr_mem_r[rd_ptr_r];
    assign mem_data  = data_mem_r[rd_ptr_r];
    assign count     = count_r;
    assign empty     = empty_r;
    assign full      = full_r;

    // Occupancy next-state from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy state; reset discards every pending entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_FULL);
            empty_r <= (count_nxt_s == {CW{1'b0}});
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_r[wr_ptr_r] <= st_addr;
            data_mem_r[wr_ptr_r] <= st_data;
        end
    end

    // Walk occupied entries oldest to youngest so the last match is the youngest.
    always_comb begin
        hit_s = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        hit_data_s = {DW{1'b0}};
`endif
        idx_s = rd_ptr_r;
        off_s = {CW{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            if ((off_s < count_r) && (addr_mem_r[idx_s][AW-1:2] == ld_addr[AW-1:2])) begin
                hit_s = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                hit_data_s = data_mem_r[idx_s];
`endif
            end else begin
                hit_s = hit_s;
            end
            idx_s = idx_s + PTR_ONE;
            off_s = off_s + CNT_ONE;
        end
    end

    // Load-check outputs, qualified by ld_valid.
    always_comb begin
        ld_fwd   = 1'b0;
        ld_data  = {DW{1'b0}};
        ld_stall = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
        if (ld_valid && hit_s) begin
            ld_fwd  = 1'b1;
            ld_data = hit_data_s;
        end else begin
            ld_fwd  = 1'b0;
            ld_data = {DW{1'b0}};
        end
`else
        ld_stall = ld_valid & hit_s;
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer; covers the default build and STORE_BUFFER_FWD_EN.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_fwd;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_fwd(ld_fwd), .ld_data(ld_data),
        .ld_stall(ld_stall),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp3 [4];

    initial begin
        reset = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
        ld_valid = 1'b1; ld_addr = 32'h0; mem_ready = 1'b0;
        #12;
        check("rst_st_ready",  64'(st_ready),  64'd1);
        check("rst_empty",     64'(empty),     64'd1);
        check("rst_full",      64'(full),      64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_ld_fwd",    64'(ld_fwd),    64'd0);
        check("rst_ld_stall",  64'(ld_stall),  64'd0);
        check("rst_ld_data",   64'(ld_data),   64'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single store, fast memory
        st_valid = 1'b1; st_addr = 32'h64; st_data = 32'd7; mem_ready = 1'b1;
        tick();
        st_valid = 1'b0;
        check("t1_mem_valid", 64'(mem_valid), 64'd1);
        check("t1_mem_addr",  64'(mem_addr),  64'h64);
        check("t1_mem_data",  64'(mem_data),  64'd7);
        check("t1_count",     64'(count),     64'd1);
        tick();
        check("t1_empty_after_pop", 64'(empty), 64'd1);
        check("t1_count_after_pop", 64'(count), 64'd0);

        // Fill while memory is busy, hold a 5th store
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h10 + 32'(4*i); st_data = 32'(i+1);
            tick();
        end
        st_addr = 32'h40; st_data = 32'd5;
        check("t2_full",     64'(full),     64'd1);
        check("t2_st_ready", 64'(st_ready), 64'd0);
        check("t2_count4",   64'(count),    64'd4);
        tick();
        check("t2_held_count", 64'(count),    64'd4);
        check("t2_held_head",  64'(mem_data), 64'd1);
`ifndef STORE_BUFFER_FWD_EN
        ld_valid = 1'b1; ld_addr = 32'h18; #1;
        check("t2_stall_hit",     64'(ld_stall), 64'd1);
        check("t2_fwd_off",       64'(ld_fwd),   64'd0);
        ld_addr = 32'h1A; #1;
        check("t2_stall_byteoff", 64'(ld_stall), 64'd1);
        ld_addr = 32'h40; #1;
        check("t2_stall_miss",    64'(ld_stall), 64'd0);
        ld_valid = 1'b0; ld_addr = 32'h18; #1;
        check("t2_stall_novalid", 64'(ld_stall), 64'd0);
`endif
        mem_ready = 1'b1; #1;
        check("t2_head1", 64'(mem_data), 64'd1);
        tick();
        check("t2_ready_after_pop", 64'(st_ready), 64'd1);
        check("t2_count3",          64'(count),    64'd3);
        check("t2_head2",           64'(mem_data), 64'd2);
        tick();
        st_valid = 1'b0;
        check("t2_count_pushpop", 64'(count),    64'd3);
        check("t2_head3",         64'(mem_data), 64'd3);
        tick();
        check("t2_head4", 64'(mem_data), 64'd4);
        tick();
        check("t2_head5",  64'(mem_data), 64'd5);
        check("t2_count1", 64'(count),    64'd1);
        tick();
        check("t2_empty", 64'(empty), 64'd1);

        // Full buffer with store pending and memory ready: pop first, push next cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1; st_addr = 32'h10 + 32'(4*i); st_data = 32'(i+1);
            tick();
        end
        st_addr = 32'h80; st_data = 32'h55; mem_ready = 1'b1; #1;
        check("t3_st_ready_full", 64'(st_ready), 64'd0);
        tick();
        check("t3_count_pop_only", 64'(count),    64'd3);
        check("t3_st_ready",       64'(st_ready), 64'd1);
        mem_ready = 1'b0;
        tick();
        st_valid = 1'b0;
        check("t3_count_back4", 64'(count), 64'd4);
        check("t3_full_again",  64'(full),  64'd1);
        exp3[0] = 32'd2; exp3[1] = 32'd3; exp3[2] = 32'd4; exp3[3] = 32'h55;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t3_drain%0d", i), 64'(mem_data), 64'(exp3[i]));
            tick();
        end
        check("t3_empty", 64'(empty), 64'd1);

`ifdef STORE_BUFFER_FWD_EN
        // Forwarding returns the youngest matching store
        mem_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'hA; tick();
        st_data = 32'hB; tick();
        st_addr = 32'h30; st_data = 32'hC; tick();
        st_valid = 1'b0;
        ld_valid = 1'b1; ld_addr = 32'h20; #1;
        check("f_fwd_hit",   64'(ld_fwd),   64'd1);
        check("f_fwd_data",  64'(ld_data),  64'hB);
        check("f_no_stall",  64'(ld_stall), 64'd0);
        ld_addr = 32'h24; #1;
        check("f_miss_fwd",  64'(ld_fwd),   64'd0);
        check("f_miss_data", 64'(ld_data),  64'd0);
        ld_addr = 32'h30; #1;
        check("f_data_c",    64'(ld_data),  64'hC);
        ld_valid = 1'b0;
        mem_ready = 1'b1;
        tick(); tick(); tick();
        check("f_empty", 64'(empty), 64'd1);
`else
        // Stall until the matching store drains; a same-cycle push is not yet visible
        mem_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'h20; st_data = 32'hA;
        ld_valid = 1'b1; ld_addr = 32'h20; #1;
        check("s_push_invisible", 64'(ld_stall), 64'd0);
        tick();
        st_valid = 1'b0; #1;
        check("s_stall",      64'(ld_stall), 64'd1);
        check("s_fwd_zero",   64'(ld_fwd),   64'd0);
        check("s_data_zero",  64'(ld_data),  64'd0);
        ld_addr = 32'h24; #1;
        check("s_miss",       64'(ld_stall), 64'd0);
        ld_addr = 32'h20; mem_ready = 1'b1; #1;
        check("s_stall_popping", 64'(ld_stall), 64'd1);
        tick();
        check("s_stall_cleared", 64'(ld_stall), 64'd0);
        check("s_empty",         64'(empty),    64'd1);
        ld_valid = 1'b0;
`endif

        // Reset mid-drain discards pending entries
        mem_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'h100; st_data = 32'h1; tick();
        st_addr = 32'h104; st_data = 32'h2; tick();
        st_valid = 1'b0;
        check("r_count2", 64'(count), 64'd2);
        #3;
        reset = 1'b1; #1;
        check("r_mem_valid", 64'(mem_valid), 64'd0);
        check("r_count",     64'(count),     64'd0);
        check("r_empty",     64'(empty),     64'd1);
        check("r_st_ready",  64'(st_ready),  64'd1);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        tick(); tick();
        check("r_stays_idle", 64'(mem_valid), 64'd0);
        st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h33; mem_ready = 1'b0;
        tick();
        st_valid = 1'b0;
        check("r_new_valid", 64'(mem_valid), 64'd1);
        check("r_new_addr",  64'(mem_addr),  64'h200);
        check("r_new_data",  64'(mem_data),  64'h33);
        check("r_new_count", 64'(count),     64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
